pipelined_prefix_addsub: RTL and testbench
==========================================

Name: pipelined_prefix_addsub

Overview:
- Three-stage pipelined Kogge-Stone prefix adder/subtractor with valid/ready handshaking on both sides.
- Stage 1 forms bitwise generate/propagate terms.
- Stage 2 resolves group generates through the log2(N)-level prefix tree built from gray/black cell logic (G(i:j) = G(i:k) | P(i:k)&G(k-1:j)).
- Stage 3 forms sum and flags.
- Serves as the datapath arithmetic unit feeding the ALU result mux. It gives the reverse operation (A-B) alongside addition.

Parameters:
- N, 16, operand width in bits; must be a power of two, 4..64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands/op valid this cycle
- in_ready  output  1  block can accept operands this cycle
- in_a  input  N  operand A
- in_b  input  N  operand B
- in_sub  input  1  0: A+B+cin; 1: A-B (B inverted, carry-in forced 1)
- in_cin  input  1  carry-in, used only when in_sub=0
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_sum  output  N  result
- out_cout  output  1  carry out of MSB; for subtract, 1 = no borrow
- out_ovf  output  1  signed two's-complement overflow
- out_zero  output  1  out_sum == 0

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits are 0.
  - out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_zero=0.
  - Pipeline data registers are cleared to 0.
  - Reset mid-operation discards all in-flight results; nothing is emitted after release until new inputs are accepted.
- Handshake:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - out_* values are held stable while out_valid=1 and out_ready=0.
- Pipeline advance: all three stages advance together when adv = out_ready | ~out_valid.
  - in_ready = adv, combinational.
  - No bubble collapsing.
  - A stage's valid bit loads the upstream valid bit on adv and holds otherwise.
- Latency:
  - Accepted operation appears on out_valid exactly 3 cycles after acceptance when out_ready is held 1.
  - Throughput is 1 operation per cycle.
- Stage 1 (register):
  - b' = in_sub ? ~in_b : in_b; c0 = in_sub ? 1 : in_cin.
  - g[i] = a[i]&b'[i], p[i] = a[i]^b'[i].
  - Register p, g, c0, a[N-1], b'[N-1].
- Stage 2 (register):
  - Kogge-Stone tree of log2(N) levels, with c0 folded in as G(-1:-1)=c0.
  - Register carry vector c[N:0] (c[i] = G(i-1:-1)), p, a[N-1], b'[N-1].
  - Tree levels are combinational within this stage.
- Stage 3 (register):
  - sum[i] = p[i]^c[i]; cout = c[N]; ovf = c[N]^c[N-1]; zero = ~|sum.
- Arithmetic is modulo 2^N; no saturation.
- Simultaneous in_valid with out_valid & ~out_ready: the input is not accepted (in_ready=0), and in_a/in_b are ignored that cycle.
- Changing in_sub or in_cin across consecutive operations has no cross-operation effect; each operation carries its own mode through the pipeline.
- Boundary cases, N=16:
  - 0xFFFF+0x0001 → sum 0x0000, cout 1, ovf 0, zero 1.
  - 0x7FFF+0x0001 → ovf 1.
  - 0x8000-0x0001 → sum 0x7FFF, ovf 1, cout 1.

Test Plan:
- Reset, then in_valid=1 with A=0x1234, B=0x4321, sub=0, cin=0, out_ready=1 → out_valid rises 3 cycles later; sum=0x5555, cout=0, ovf=0, zero=0.
- Subtract 0x0005-0x0007 → sum=0xFFFE, cout=0 (borrow), ovf=0. Subtract 0x8000-0x0001 → sum=0x7FFF, cout=1, ovf=1.
- Add 0xFFFF+0x0000 with cin=1 → sum=0x0000, cout=1, zero=1. Add 0x7FFF+0x0001 → sum=0x8000, ovf=1.
- Back-to-back stream of 8 random ops with out_ready=1 → 8 consecutive out_valid cycles, in order, each matching a reference model.
- Backpressure: out_ready=0 for 5 cycles mid-stream → in_ready=0 while out_valid=1; out_* held stable; no op lost or duplicated after out_ready returns.
- Assert rst_n=0 for 1 cycle with 3 ops in flight → out_valid=0 immediately (asynchronous); no stale results after release.

Source files
------------

// File: rtl/pipelined_prefix_addsub.sv
// Three-stage Kogge-Stone adder/subtractor with valid/ready handshake on both sides.
// Stage 1 forms bitwise g/p, stage 2 resolves carries through the prefix tree, stage 3 forms sum/flags.
module pipelined_prefix_addsub #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_sub,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         out_zero
);

  localparam int unsigned Lvls = $clog2(N);

  logic adv;

  // Stage 1 state
  logic         s1_valid_q;
  logic [N-1:0] s1_p_q, s1_g_q;
  logic         s1_c0_q, s1_amsb_q, s1_bmsb_q;
  logic [N-1:0] s1_p_d, s1_g_d, b_mod;
  logic         s1_c0_d;

  // Stage 2 state
  logic         s2_valid_q;
  logic [N:0]   s2_c_q;
  logic [N-1:0] s2_p_q;
  logic         s2_amsb_q, s2_bmsb_q;
  logic [N:0]   s2_c_d;

  // Stage 3 state
  logic         s3_valid_q;
  logic [N-1:0] s3_sum_q;
  logic         s3_cout_q, s3_ovf_q, s3_zero_q;
  logic [N-1:0] s3_sum_d;
  logic         s3_cout_d, s3_ovf_d, s3_zero_d;

  // Prefix tree: gl[l][i] / pl[l][i] are group terms after l levels.
  logic [Lvls:0][N-1:0]   gl;
  logic [Lvls-1:0][N-1:0] pl;

  assign adv      = out_ready | ~s3_valid_q;
  assign in_ready = adv;

  always_comb begin
    b_mod   = in_sub ? ~in_b : in_b;
    s1_c0_d = in_sub | in_cin;
    s1_g_d  = in_a & b_mod;
    s1_p_d  = in_a ^ b_mod;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_p_q     <= '0;
      s1_g_q     <= '0;
      s1_c0_q    <= 1'b0;
      s1_amsb_q  <= 1'b0;
      s1_bmsb_q  <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      s1_p_q     <= s1_p_d;
      s1_g_q     <= s1_g_d;
      s1_c0_q    <= s1_c0_d;
      s1_amsb_q  <= in_a[N-1];
      s1_bmsb_q  <= b_mod[N-1];
    end
  end

  // Carry-in folded into bit 0 so every complete span reaches G(i:-1).
  assign gl[0] = {s1_g_q[N-1:1], s1_g_q[0] | (s1_p_q[0] & s1_c0_q)};
  assign pl[0] = s1_p_q;

  for (genvar l = 0; l < Lvls; l++) begin : g_lvl
    for (genvar i = 0; i < N; i++) begin : g_bit
      if (i >= (1 << l)) begin : g_black
        assign gl[l+1][i] = gl[l][i] | (pl[l][i] & gl[l][i-(1<<l)]);
        if (l + 1 < Lvls) begin : g_p
          assign pl[l+1][i] = pl[l][i] & pl[l][i-(1<<l)];
        end
      end else begin : g_pass
        assign gl[l+1][i] = gl[l][i];
        if (l + 1 < Lvls) begin : g_p
          assign pl[l+1][i] = pl[l][i];
        end
      end
    end
  end

  assign s2_c_d = {gl[Lvls], s1_c0_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_c_q     <= '0;
      s2_p_q     <= '0;
      s2_amsb_q  <= 1'b0;
      s2_bmsb_q  <= 1'b0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      s2_c_q     <= s2_c_d;
      s2_p_q     <= s1_p_q;
      s2_amsb_q  <= s1_amsb_q;
      s2_bmsb_q  <= s1_bmsb_q;
    end
  end

  always_comb begin
    s3_sum_d  = s2_p_q ^ s2_c_q[N-1:0];
    s3_cout_d = s2_c_q[N];
    // Sign rule on the effective operands; equivalent to c[N] ^ c[N-1].
    s3_ovf_d  = (s2_amsb_q ~^ s2_bmsb_q) & (s2_amsb_q ^ s3_sum_d[N-1]);
    s3_zero_d = ~|s3_sum_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid_q <= 1'b0;
      s3_sum_q   <= '0;
      s3_cout_q  <= 1'b0;
      s3_ovf_q   <= 1'b0;
      s3_zero_q  <= 1'b0;
    end else if (adv) begin
      s3_valid_q <= s2_valid_q;
      s3_sum_q   <= s3_sum_d;
      s3_cout_q  <= s3_cout_d;
      s3_ovf_q   <= s3_ovf_d;
      s3_zero_q  <= s3_zero_d;
    end
  end

  assign out_valid = s3_valid_q;
  assign out_sum   = s3_sum_q;
  assign out_cout  = s3_cout_q;
  assign out_ovf   = s3_ovf_q;
  assign out_zero  = s3_zero_q;

endmodule

// File: tb/tb_pipelined_prefix_addsub.sv
// Directed bench for pipelined_prefix_addsub (N=16): latency, arithmetic corners,
// streaming, backpressure hold and asynchronous reset flush.
module tb_pipelined_prefix_addsub;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0, in_ready;
  logic [N-1:0] in_a = '0, in_b = '0;
  logic         in_sub = 1'b0, in_cin = 1'b0;
  logic         out_valid, out_ready = 1'b1;
  logic [N-1:0] out_sum;
  logic         out_cout, out_ovf, out_zero;

  typedef struct packed {
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  res_t exp_q[$];
  res_t held;
  int   nvec = 0, nmis = 0, nout = 0;
  logic last_ov, stalled_prev = 1'b0, acc;

  pipelined_prefix_addsub #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_sub   (in_sub),
    .in_cin   (in_cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf),
    .out_zero (out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Independent reference: plain wide addition on the effective operands.
  function automatic res_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic sub, input logic cin);
    logic [N-1:0] bb;
    logic [N:0]   t;
    res_t         r;
    bb     = sub ? ~b : b;
    t      = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, (sub ? 1'b1 : cin)};
    r.sum  = t[N-1:0];
    r.cout = t[N];
    r.ovf  = (a[N-1] == bb[N-1]) && (t[N-1] != a[N-1]);
    r.zero = (t[N-1:0] == '0);
    return r;
  endfunction

  // One clock: drive inputs, check outputs about to transfer, then cross the edge.
  task automatic step(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic sub, input logic cin, input logic rdy, input res_t e,
                      output logic accepted);
    res_t e2;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_sub    = sub;
    in_cin    = cin;
    out_ready = rdy;
    #1;
    last_ov = out_valid;
    if (out_valid && !out_ready) begin
      chk("in_ready_during_stall", in_ready, 0);
      if (stalled_prev)
        chk("held_outputs", {out_sum, out_cout, out_ovf, out_zero}, held);
      held         = {out_sum, out_cout, out_ovf, out_zero};
      stalled_prev = 1'b1;
    end else begin
      stalled_prev = 1'b0;
    end
    if (out_valid && out_ready) begin
      nout++;
      if (exp_q.size() == 0) begin
        chk("spurious_output", out_valid, 0);
      end else begin
        e2 = exp_q.pop_front();
        chk("sum", out_sum, e2.sum);
        chk("cout", out_cout, e2.cout);
        chk("ovf", out_ovf, e2.ovf);
        chk("zero", out_zero, e2.zero);
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    logic a;
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0, a);
  endtask

  // Single directed op with hand-computed result; checks exact 3-cycle latency.
  task automatic dir(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                     input logic sub, input logic cin, input logic [N-1:0] s,
                     input logic co, input logic ov, input logic z);
    logic a1;
    step(1'b1, a, b, sub, cin, 1'b1, {s, co, ov, z}, a1);
    chk({tag, "_accepted"}, a1, 1);
    idle();
    chk({tag, "_lat1"}, last_ov, 0);
    idle();
    chk({tag, "_lat2"}, last_ov, 0);
    idle();
    chk({tag, "_lat3"}, last_ov, 1);
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    logic         rs, rc;
    int           idx, n0;

    // Reset
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_flags", {out_cout, out_ovf, out_zero}, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    idle();

    // Directed arithmetic
    dir("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    dir("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    dir("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    dir("add_cin_wrap", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    dir("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    dir("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    dir("sub_ignores_cin", 16'h0003, 16'h0003, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    dir("add_cin", 16'h00FF, 16'h0F00, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);

    // Back-to-back stream: 8 accepts then 3 idle cycles must yield all 8 results.
    n0 = nout;
    for (int i = 0; i < 8; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      step(1'b1, ra, rb, rs, rc, 1'b1, model(ra, rb, rs, rc), acc);
      chk("stream_accepted", acc, 1);
    end
    repeat (3) idle();
    chk("stream_count", nout - n0, 8);
    chk("stream_drained", exp_q.size(), 0);

    // Backpressure: out_ready low for 5 cycles mid-stream.
    n0  = nout;
    idx = 0;
    ra  = N'($urandom);
    rb  = N'($urandom);
    rs  = 1'($urandom_range(0, 1));
    rc  = 1'($urandom_range(0, 1));
    for (int c = 0; c < 40 && (idx < 8 || exp_q.size() > 0); c++) begin
      step(idx < 8, ra, rb, rs, rc, !(c >= 4 && c < 9), model(ra, rb, rs, rc), acc);
      if (acc) begin
        idx++;
        ra = N'($urandom);
        rb = N'($urandom);
        rs = 1'($urandom_range(0, 1));
        rc = 1'($urandom_range(0, 1));
      end
    end
    chk("bp_all_accepted", idx, 8);
    chk("bp_count", nout - n0, 8);
    chk("bp_drained", exp_q.size(), 0);

    // Asynchronous reset with three ops in flight.
    for (int i = 0; i < 3; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      step(1'b1, ra, rb, 1'b0, 1'b0, 1'b1, model(ra, rb, 1'b0, 1'b0), acc);
    end
    in_valid = 1'b0;
    chk("pre_reset_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_sum", out_sum, 0);
    chk("async_rst_flags", {out_cout, out_ovf, out_zero}, 0);
    exp_q.delete();
    stalled_prev = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    n0 = nout;
    repeat (5) idle();
    chk("no_stale_after_reset", nout - n0, 0);
    dir("post_reset", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
